// File: rtl/heartbeat_pulse_gen.sv
// Heartbeat source: turns a BPM setting into a train of PULSE_W-cycle pulses spaced
// floor(60*CLK_HZ/bpm) cycles apart, with the period found by a bit-serial divider.
module heartbeat_pulse_gen #(
   parameter int CLK_HZ   = 1000,
   parameter int PULSE_W  = 5,
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [7:0]          bpm_in,
   input  logic                bpm_load,
   output logic                pulse_out,
   output logic                beat_tick,
   output logic                busy,
   output logic [PERIOD_W-1:0] period_out
);

   localparam int                  CNT_W      = $clog2(PERIOD_W);
   localparam logic [PERIOD_W-1:0] NUMER      = PERIOD_W'(60 * CLK_HZ);
   localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_W + 1);
   localparam logic [PERIOD_W-1:0] HIGH_LAST  = PERIOD_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0]    DIV_LAST   = CNT_W'(PERIOD_W - 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, LOW, HIGH} state_t;

   state_t              state;
   logic [7:0]          divisor;
   logic [PERIOD_W-1:0] numer;
   logic [PERIOD_W-1:0] rem;
   logic [PERIOD_W-1:0] phase;
   logic [CNT_W-1:0]    div_cnt;

   logic [PERIOD_W:0]   trial;
   logic                q_bit;
   logic [PERIOD_W-1:0] rem_sub;
   logic [PERIOD_W-1:0] quot_final;
   logic [PERIOD_W-1:0] low_last;

   // trial's top bit is the guard bit; once q_bit is set the true difference
   // is below the divisor, so a PERIOD_W-bit subtraction is exact.
   always_comb begin
      trial      = {rem, numer[PERIOD_W-1]};
      q_bit      = trial >= {{(PERIOD_W-7){1'b0}}, divisor};
      rem_sub    = trial[PERIOD_W-1:0] - PERIOD_W'(divisor);
      quot_final = {numer[PERIOD_W-2:0], q_bit};
      low_last   = period_out - PERIOD_W'(PULSE_W) - PERIOD_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pulse_out  <= 1'b0;
         beat_tick  <= 1'b0;
         busy       <= 1'b0;
         period_out <= '0;
         divisor    <= '0;
         numer      <= '0;
         rem        <= '0;
         phase      <= '0;
         div_cnt    <= '0;
      end else begin
         beat_tick <= 1'b0;
         if (bpm_load && state != DIVIDE) begin
            // A new rate aborts any beat in progress, including the rising edge.
            pulse_out <= 1'b0;
            if (bpm_in != 8'd0) begin
               state   <= DIVIDE;
               busy    <= 1'b1;
               divisor <= bpm_in;
               numer   <= NUMER;
               rem     <= '0;
               div_cnt <= '0;
            end else begin
               state      <= IDLE;
               period_out <= '0;
            end
         end else begin
            case (state)
               IDLE: begin
                  pulse_out <= 1'b0;
                  if (enable && period_out != '0) begin
                     state <= LOW;
                     phase <= '0;
                  end
               end
               DIVIDE: begin
                  numer   <= {numer[PERIOD_W-2:0], q_bit};
                  rem     <= q_bit ? rem_sub : trial[PERIOD_W-1:0];
                  div_cnt <= div_cnt + 1'b1;
                  if (div_cnt == DIV_LAST) begin
                     busy       <= 1'b0;
                     period_out <= (quot_final < MIN_PERIOD) ? MIN_PERIOD : quot_final;
                     phase      <= '0;
                     state      <= enable ? LOW : IDLE;
                  end
               end
               LOW: begin
                  if (!enable) begin
                     state     <= IDLE;
                     pulse_out <= 1'b0;
                  end else if (phase == low_last) begin
                     state     <= HIGH;
                     phase     <= '0;
                     pulse_out <= 1'b1;
                     beat_tick <= 1'b1;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
               HIGH: begin
                  if (!enable) begin
                     state     <= IDLE;
                     pulse_out <= 1'b0;
                  end else if (phase == HIGH_LAST) begin
                     state     <= LOW;
                     phase     <= '0;
                     pulse_out <= 1'b0;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
               default: begin
                  state     <= IDLE;
                  pulse_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Bench for heartbeat_pulse_gen: stimulus pushes expected busy-fall times, periods
// and beat times into queues; a negedge monitor pops and compares what the DUT shows.
module tb_heartbeat_pulse_gen;

   localparam int CLK_HZ   = 1000;
   localparam int PULSE_W  = 5;
   localparam int PERIOD_W = 24;
   localparam int NEVER    = 1 << 30;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                enable = 1'b0;
   logic [7:0]          bpm_in = 8'd0;
   logic                bpm_load = 1'b0;
   logic                pulse_out;
   logic                beat_tick;
   logic                busy;
   logic [PERIOD_W-1:0] period_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int per   = 0;
   int cut   = NEVER;
   int exp_tick_q[$];
   int exp_fall_q[$];
   int exp_per_q[$];

   heartbeat_pulse_gen #(.CLK_HZ(CLK_HZ), .PULSE_W(PULSE_W), .PERIOD_W(PERIOD_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .bpm_in(bpm_in), .bpm_load(bpm_load),
      .pulse_out(pulse_out), .beat_tick(beat_tick), .busy(busy), .period_out(period_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: the period is plain integer division, clamped so LOW lasts >= 1 cycle.
   function automatic int model_period(input int b);
      int q;
      q = (60 * CLK_HZ) / b;
      return (q < PULSE_W + 1) ? PULSE_W + 1 : q;
   endfunction

   // Beats start p-PULSE_W cycles after the LOW phase starts at `base`, then every p.
   task automatic sched(input int base, input int p, input int stop);
      for (int t = base + p - PULSE_W; t < stop; t += p) exp_tick_q.push_back(t);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_load(input int b, output int lc);
      bpm_in   = 8'(b);
      bpm_load = 1'b1;
      lc       = cyc + 1;
      @(negedge clk);
      bpm_load = 1'b0;
   endtask

   // Load nonzero bpm, optionally retry a load while busy, run `hold` cycles past busy fall.
   task automatic load_run(input int b, input int hold, input int extra);
      int lc, f;
      cut = cyc + 1;
      do_load(b, lc);
      f   = lc + PERIOD_W;
      per = model_period(b);
      exp_fall_q.push_back(f);
      exp_per_q.push_back(per);
      sched(f, per, f + hold);
      if (extra >= 0) begin
         repeat ($urandom_range(1, 18)) @(negedge clk);
         bpm_in   = 8'(extra);
         bpm_load = 1'b1;
         @(negedge clk);
         bpm_load = 1'b0;
      end
      wait_until(f + hold - 1);
   endtask

   task automatic load_zero(input int hold);
      int lc;
      cut = cyc + 1;
      do_load(0, lc);
      per = 0;
      check("period_after_zero", period_out, 0);
      check("pulse_after_zero", pulse_out, 0);
      repeat (hold) @(negedge clk);
   endtask

   task automatic disable_run(input int hold, input int after);
      int r;
      cut    = cyc + 1;
      enable = 1'b0;
      repeat (hold + 1) @(negedge clk);
      check("period_kept", period_out, per);
      check("pulse_held_low", pulse_out, 0);
      enable = 1'b1;
      r      = cyc + 1;
      if (per != 0) sched(r, per, r + after);
      wait_until(r + after - 1);
   endtask

   // bpm_load together with enable falling: division completes, then output holds.
   task automatic load_disable_run(input int b, input int hold, input int after);
      int lc, f, r;
      cut    = cyc + 1;
      enable = 1'b0;
      do_load(b, lc);
      f   = lc + PERIOD_W;
      per = model_period(b);
      exp_fall_q.push_back(f);
      exp_per_q.push_back(per);
      wait_until(f + hold);
      check("held_after_divide", pulse_out, 0);
      enable = 1'b1;
      r      = cyc + 1;
      sched(r, per, r + after);
      wait_until(r + after - 1);
   endtask

   // Monitor: every beat, busy fall and pulse fall is matched against the queues.
   logic busy_d = 1'b0, pulse_d = 1'b0;
   int   busy_len = 0, rise_at = 0;
   always @(negedge clk) begin
      if (!reset) begin
         if (beat_tick) begin
            if (exp_tick_q.size() == 0) check("unexpected_tick", cyc, -1);
            else check("tick_time", cyc, exp_tick_q.pop_front());
         end
         if (pulse_out && !pulse_d) begin
            check("rise_has_tick", beat_tick, 1);
            rise_at = cyc;
         end
         if (!pulse_out && pulse_d)
            check("pulse_width", cyc - rise_at,
                  (cut > rise_at && cut - rise_at < PULSE_W) ? cut - rise_at : PULSE_W);
         if (busy) busy_len++;
         if (!busy && busy_d) begin
            check("busy_len", busy_len, PERIOD_W);
            if (exp_fall_q.size() == 0) check("unexpected_busy_fall", cyc, -1);
            else begin
               check("busy_fall_time", cyc, exp_fall_q.pop_front());
               check("period_out", period_out, exp_per_q.pop_front());
            end
         end
         if (!busy) busy_len = 0;
      end
      busy_d  = busy;
      pulse_d = pulse_out;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f, kind, b;
      repeat (10) @(negedge clk);
      check("rst_pulse", pulse_out, 0);
      check("rst_tick", beat_tick, 0);
      check("rst_busy", busy, 0);
      check("rst_period", period_out, 0);
      reset  = 1'b0;
      enable = 1'b1;
      @(negedge clk);

      load_run(60, 995 + 2000 + 10, -1);
      load_run(90, 666 * 2 + 50, -1);
      load_run(120, 500 * 2 + 50, -1);
      load_run(255, 235 * 3 + 20, -1);
      load_run(1, 1000, -1);
      load_zero(3000);
      load_run(120, 996, -1);            // abort on the 2nd HIGH cycle of the 2nd beat
      load_run(60, 995 + 1000 + 3, 90);  // second load during busy must be ignored
      load_run(120, 200, -1);
      disable_run(3000, 495 + 500 + 3);
      load_disable_run(90, 100, 700);

      for (int i = 0; i < 12; i++) begin
         kind = $urandom_range(0, 9);
         b    = $urandom_range(60, 255);
         if (kind <= 5)
            load_run(b, $urandom_range(1, model_period(b) * 5 / 2),
                     (kind == 0) ? $urandom_range(0, 255) : -1);
         else if (kind == 6) load_zero($urandom_range(200, 800));
         else if (kind == 7) disable_run($urandom_range(10, 1500), $urandom_range(1, 1200));
         else if (kind == 8) load_disable_run(b, $urandom_range(1, 300), $urandom_range(1, 1200));
         else load_run(b, model_period(b) - PULSE_W + $urandom_range(0, PULSE_W), -1);
      end

      // Reset in the middle of a beat: outputs drop without waiting for a clock edge.
      load_run(120, 497, -1);
      f = cyc + 1 - 497;
      wait_until(f + 496);
      check("pulse_high_before_reset", pulse_out, 1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_pulse", pulse_out, 0);
      check("async_rst_period", period_out, 0);
      check("async_rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("rst_hold_pulse", pulse_out, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("pulse_idle_after_reset", pulse_out, 0);
      check("ticks_left", exp_tick_q.size(), 0);
      check("falls_left", exp_fall_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
